// File: rtl/t_state_sequencer_if.sv
// Control-bus bundle between the instruction sequencer and the receive/enable
// control: instruction/flag inputs, T-state lines, phase strobes and status.
interface t_state_sequencer_if;
  logic        run;
  logic [7:0]  ir;
  logic [3:0]  flags;

  logic        seq1;
  logic        seq2;
  logic        seq3;
  logic        seq4;
  logic        seq5;
  logic        seq6;

  logic        cpt4;
  logic        cpt5;
  logic        cpt6;
  logic        LD4;
  logic        LD5;
  logic        ST4;
  logic        ST5;
  logic        DATA4;
  logic        DATA5;
  logic        DATA6;
  logic        JMPR4;
  logic        JMP4;
  logic        JMP5;
  logic        JCON4;
  logic        JCON5;
  logic        JCON6;
  logic        CLR4;
  logic        DISP4;

  logic        last;
  logic        halted;
  logic [15:0] icount;

  modport master (
    output run, ir, flags,
    input  seq1, seq2, seq3, seq4, seq5, seq6,
    input  cpt4, cpt5, cpt6, LD4, LD5, ST4, ST5, DATA4, DATA5, DATA6,
    input  JMPR4, JMP4, JMP5, JCON4, JCON5, JCON6, CLR4, DISP4,
    input  last, halted, icount
  );

  modport slave (
    input  run, ir, flags,
    output seq1, seq2, seq3, seq4, seq5, seq6,
    output cpt4, cpt5, cpt6, LD4, LD5, ST4, ST5, DATA4, DATA5, DATA6,
    output JMPR4, JMP4, JMP5, JCON4, JCON5, JCON6, CLR4, DISP4,
    output last, halted, icount
  );
endinterface

// File: rtl/t_state_sequencer.sv
// T-state sequencer: 3-state fetch plus a 1..3 state execute, one-hot state,
// combinational phase strobes and a retired-instruction counter.
module t_state_sequencer (
  input  logic                 Iclk,
  input  logic                 rst_n,
  t_state_sequencer_if.slave   bus
);

  typedef enum logic [6:0] {
    IDLE = 7'b0000001,
    T1   = 7'b0000010,
    T2   = 7'b0000100,
    T3   = 7'b0001000,
    T4   = 7'b0010000,
    T5   = 7'b0100000,
    T6   = 7'b1000000
  } state_t;

  typedef enum logic [3:0] {
    C_ALU,
    C_LD,
    C_ST,
    C_DATA,
    C_JMPR,
    C_JMP,
    C_JCON,
    C_CLR,
    C_DISP
  } opclass_t;

  state_t      state;
  state_t      state_nxt;
  opclass_t    opclass;
  logic        taken;
  logic [2:0]  final_t;
  logic        last;
  logic [15:0] icount_q;

  logic s1, s2, s3, s4, s5, s6;

  // Number of the T-state that retires an instruction of the given class.
  function automatic logic [2:0] final_tstate(input opclass_t c, input logic tk);
    logic [2:0] f;
    f = 3'd6;
    unique case (c)
      C_ALU:  f = 3'd6;
      C_LD:   f = 3'd5;
      C_ST:   f = 3'd5;
      C_DATA: f = 3'd6;
      C_JMPR: f = 3'd4;
      C_JMP:  f = 3'd5;
      C_JCON: f = tk ? 3'd6 : 3'd5;
      C_CLR:  f = 3'd4;
      C_DISP: f = 3'd4;
      default: f = 3'd6;
    endcase
    return f;
  endfunction

  assign s1 = (state == T1);
  assign s2 = (state == T2);
  assign s3 = (state == T3);
  assign s4 = (state == T4);
  assign s5 = (state == T5);
  assign s6 = (state == T6);

  always_comb begin
    opclass = C_ALU;
    if (!bus.ir[7]) begin
      unique case (bus.ir[6:4])
        3'b000: opclass = C_LD;
        3'b001: opclass = C_ST;
        3'b010: opclass = C_DATA;
        3'b011: opclass = C_JMPR;
        3'b100: opclass = C_JMP;
        3'b101: opclass = C_JCON;
        3'b110: opclass = C_CLR;
        3'b111: opclass = C_DISP;
        default: opclass = C_ALU;
      endcase
    end
  end

  assign taken   = |(bus.ir[3:0] & bus.flags);
  assign final_t = final_tstate(opclass, taken);

  // Only execute states can retire; fetch states are never final.
  assign last = (s4 && (final_t == 3'd4)) ||
                (s5 && (final_t == 3'd5)) ||
                (s6 && (final_t == 3'd6));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = bus.run ? T1 : IDLE;
      T1:      state_nxt = T2;
      T2:      state_nxt = T3;
      T3:      state_nxt = T4;
      T4:      state_nxt = last ? (bus.run ? T1 : IDLE) : T5;
      T5:      state_nxt = last ? (bus.run ? T1 : IDLE) : T6;
      T6:      state_nxt = bus.run ? T1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Iclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Iclk or negedge rst_n) begin
    if (!rst_n) begin
      icount_q <= 16'h0000;
    end else if (last) begin
      icount_q <= icount_q + 16'h0001;
    end
  end

  always_comb begin
    bus.cpt4  = 1'b0;
    bus.cpt5  = 1'b0;
    bus.cpt6  = 1'b0;
    bus.LD4   = 1'b0;
    bus.LD5   = 1'b0;
    bus.ST4   = 1'b0;
    bus.ST5   = 1'b0;
    bus.DATA4 = 1'b0;
    bus.DATA5 = 1'b0;
    bus.DATA6 = 1'b0;
    bus.JMPR4 = 1'b0;
    bus.JMP4  = 1'b0;
    bus.JMP5  = 1'b0;
    bus.JCON4 = 1'b0;
    bus.JCON5 = 1'b0;
    bus.JCON6 = 1'b0;
    bus.CLR4  = 1'b0;
    bus.DISP4 = 1'b0;
    unique case (opclass)
      C_ALU: begin
        bus.cpt4 = s4;
        bus.cpt5 = s5;
        bus.cpt6 = s6;
      end
      C_LD: begin
        bus.LD4 = s4;
        bus.LD5 = s5;
      end
      C_ST: begin
        bus.ST4 = s4;
        bus.ST5 = s5;
      end
      C_DATA: begin
        bus.DATA4 = s4;
        bus.DATA5 = s5;
        bus.DATA6 = s6;
      end
      C_JMPR: bus.JMPR4 = s4;
      C_JMP: begin
        bus.JMP4 = s4;
        bus.JMP5 = s5;
      end
      C_JCON: begin
        bus.JCON4 = s4;
        bus.JCON5 = s5;
        bus.JCON6 = s6 && taken;
      end
      C_CLR:  bus.CLR4  = s4;
      C_DISP: bus.DISP4 = s4;
      default: ;
    endcase
  end

  assign bus.seq1   = s1;
  assign bus.seq2   = s2;
  assign bus.seq3   = s3;
  assign bus.seq4   = s4;
  assign bus.seq5   = s5;
  assign bus.seq6   = s6;
  assign bus.last   = last;
  assign bus.halted = (state == IDLE);
  assign bus.icount = icount_q;

endmodule

// File: tb/tb_t_state_sequencer.sv
// Directed bench for t_state_sequencer: walks every opcode class cycle by cycle
// and checks T-state lines, strobes, last/halted and the retire counter.
module tb_t_state_sequencer;

  logic Iclk;
  logic rst_n;
  int   checks;
  int   errors;

  t_state_sequencer_if bus();

  t_state_sequencer dut (
    .Iclk  (Iclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial Iclk = 1'b0;
  always #5 Iclk = ~Iclk;

  localparam logic [25:0] M_HALT  = 26'h1 << 0;
  localparam logic [25:0] M_LAST  = 26'h1 << 1;
  localparam logic [25:0] M_DISP4 = 26'h1 << 2;
  localparam logic [25:0] M_CLR4  = 26'h1 << 3;
  localparam logic [25:0] M_JCON6 = 26'h1 << 4;
  localparam logic [25:0] M_JCON5 = 26'h1 << 5;
  localparam logic [25:0] M_JCON4 = 26'h1 << 6;
  localparam logic [25:0] M_JMP5  = 26'h1 << 7;
  localparam logic [25:0] M_JMP4  = 26'h1 << 8;
  localparam logic [25:0] M_JMPR4 = 26'h1 << 9;
  localparam logic [25:0] M_DATA6 = 26'h1 << 10;
  localparam logic [25:0] M_DATA5 = 26'h1 << 11;
  localparam logic [25:0] M_DATA4 = 26'h1 << 12;
  localparam logic [25:0] M_ST5   = 26'h1 << 13;
  localparam logic [25:0] M_ST4   = 26'h1 << 14;
  localparam logic [25:0] M_LD5   = 26'h1 << 15;
  localparam logic [25:0] M_LD4   = 26'h1 << 16;
  localparam logic [25:0] M_CPT6  = 26'h1 << 17;
  localparam logic [25:0] M_CPT5  = 26'h1 << 18;
  localparam logic [25:0] M_CPT4  = 26'h1 << 19;
  localparam logic [25:0] M_S6    = 26'h1 << 20;
  localparam logic [25:0] M_S5    = 26'h1 << 21;
  localparam logic [25:0] M_S4    = 26'h1 << 22;
  localparam logic [25:0] M_S3    = 26'h1 << 23;
  localparam logic [25:0] M_S2    = 26'h1 << 24;
  localparam logic [25:0] M_S1    = 26'h1 << 25;

  function automatic logic [25:0] snap();
    return {bus.seq1, bus.seq2, bus.seq3, bus.seq4, bus.seq5, bus.seq6,
            bus.cpt4, bus.cpt5, bus.cpt6, bus.LD4, bus.LD5, bus.ST4, bus.ST5,
            bus.DATA4, bus.DATA5, bus.DATA6, bus.JMPR4, bus.JMP4, bus.JMP5,
            bus.JCON4, bus.JCON5, bus.JCON6, bus.CLR4, bus.DISP4,
            bus.last, bus.halted};
  endfunction

  task automatic chk_bits(input string tag, input logic [25:0] exp);
    logic [25:0] obs;
    obs = snap();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s outputs observed=%07h expected=%07h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    checks++;
    assert (bus.icount === exp) else begin
      errors++;
      $error("FAIL %s icount observed=%04h expected=%04h", tag, bus.icount, exp);
    end
  endtask

  task automatic tick();
    @(posedge Iclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.run   = 1'b0;
    bus.ir    = 8'h00;
    bus.flags = 4'h0;
    #12;
    chk_bits("reset", M_HALT);
    chk_cnt("reset", 16'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk_bits("idle_run0", M_HALT);
    end
    chk_cnt("idle_run0", 16'h0000);

    // LD followed by ALU back to back
    bus.run = 1'b1;
    bus.ir  = 8'h00;
    tick(); chk_bits("ld_t1", M_S1);
    tick(); chk_bits("ld_t2", M_S2);
    tick(); chk_bits("ld_t3", M_S3);
    tick(); chk_bits("ld_t4", M_S4 | M_LD4);
    tick(); chk_bits("ld_t5", M_S5 | M_LD5 | M_LAST);
    chk_cnt("ld_t5", 16'h0000);
    tick(); chk_bits("alu_t1", M_S1);
    chk_cnt("after_ld", 16'h0001);
    bus.ir = 8'h80;
    tick(); chk_bits("alu_t2", M_S2);
    tick(); chk_bits("alu_t3", M_S3);
    tick(); chk_bits("alu_t4", M_S4 | M_CPT4);
    tick(); chk_bits("alu_t5", M_S5 | M_CPT5);
    tick(); chk_bits("alu_t6", M_S6 | M_CPT6 | M_LAST);
    tick(); chk_bits("jcon_t1", M_S1);
    chk_cnt("after_alu", 16'h0002);

    // JCON taken
    bus.ir    = 8'h51;
    bus.flags = 4'b0001;
    tick(); chk_bits("jcont_t2", M_S2);
    tick(); chk_bits("jcont_t3", M_S3);
    tick(); chk_bits("jcont_t4", M_S4 | M_JCON4);
    tick(); chk_bits("jcont_t5", M_S5 | M_JCON5);
    tick(); chk_bits("jcont_t6", M_S6 | M_JCON6 | M_LAST);
    tick(); chk_bits("jconn_t1", M_S1);
    chk_cnt("after_jcon_taken", 16'h0003);

    // JCON not taken
    bus.flags = 4'b1110;
    tick(); chk_bits("jconn_t2", M_S2);
    tick(); chk_bits("jconn_t3", M_S3);
    tick(); chk_bits("jconn_t4", M_S4 | M_JCON4);
    tick(); chk_bits("jconn_t5", M_S5 | M_JCON5 | M_LAST);
    tick(); chk_bits("jmpr_t1", M_S1);
    chk_cnt("after_jcon_untaken", 16'h0004);

    // JMPR with run dropped mid-instruction
    bus.ir = 8'h30;
    tick(); chk_bits("jmpr_t2", M_S2);
    bus.run = 1'b0;
    tick(); chk_bits("jmpr_t3", M_S3);
    tick(); chk_bits("jmpr_t4", M_S4 | M_JMPR4 | M_LAST);
    tick(); chk_bits("jmpr_idle", M_HALT);
    chk_cnt("after_jmpr", 16'h0005);
    tick(); chk_bits("jmpr_idle2", M_HALT);
    chk_cnt("after_jmpr2", 16'h0005);

    // ST, JMP, DISP
    bus.run = 1'b1;
    bus.ir  = 8'h10;
    tick(); chk_bits("st_t1", M_S1);
    tick(); chk_bits("st_t2", M_S2);
    tick(); chk_bits("st_t3", M_S3);
    tick(); chk_bits("st_t4", M_S4 | M_ST4);
    tick(); chk_bits("st_t5", M_S5 | M_ST5 | M_LAST);
    tick(); chk_bits("jmp_t1", M_S1);
    chk_cnt("after_st", 16'h0006);
    bus.ir = 8'h40;
    tick(); chk_bits("jmp_t2", M_S2);
    tick(); chk_bits("jmp_t3", M_S3);
    tick(); chk_bits("jmp_t4", M_S4 | M_JMP4);
    tick(); chk_bits("jmp_t5", M_S5 | M_JMP5 | M_LAST);
    tick(); chk_bits("disp_t1", M_S1);
    chk_cnt("after_jmp", 16'h0007);
    bus.ir = 8'h7F;
    tick(); chk_bits("disp_t2", M_S2);
    tick(); chk_bits("disp_t3", M_S3);
    tick(); chk_bits("disp_t4", M_S4 | M_DISP4 | M_LAST);
    tick(); chk_bits("data_t1", M_S1);
    chk_cnt("after_disp", 16'h0008);

    // DATA interrupted by asynchronous reset in T5
    bus.ir = 8'h20;
    tick(); chk_bits("data_t2", M_S2);
    tick(); chk_bits("data_t3", M_S3);
    tick(); chk_bits("data_t4", M_S4 | M_DATA4);
    tick(); chk_bits("data_t5", M_S5 | M_DATA5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bits("async_reset", M_HALT);
    chk_cnt("async_reset", 16'h0000);
    bus.run = 1'b0;
    @(negedge Iclk);
    rst_n = 1'b1;
    tick(); chk_bits("post_reset", M_HALT);

    // Counter wrap, counter preloaded near the top
    force dut.icount_q = 16'hFFFE;
    #1;
    release dut.icount_q;
    #1;
    chk_cnt("preload", 16'hFFFE);
    bus.run = 1'b1;
    bus.ir  = 8'h60;
    tick(); chk_bits("clr_t1", M_S1);
    tick(); chk_bits("clr_t2", M_S2);
    tick(); chk_bits("clr_t3", M_S3);
    tick(); chk_bits("clr_t4", M_S4 | M_CLR4 | M_LAST);
    tick(); chk_cnt("count_ffff", 16'hFFFF);
    bus.run = 1'b0;
    tick(); tick();
    tick(); chk_bits("clr2_t4", M_S4 | M_CLR4 | M_LAST);
    tick(); chk_bits("clr2_idle", M_HALT);
    chk_cnt("count_wrap", 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t_state_sequencer.md
# t_state_sequencer

Instruction-cycle sequencer for the 8-bit processor. It generates the one-hot T-state lines seq1..seq6 and the per-phase decode strobes (cpt4..6, LD4/5, ST4/5, DATA4..6, JMPR4, JMP4/5, JCON4..6, CLR4, DISP4) that the receive/enable control consumes. Each instruction is a common 3-state fetch followed by a variable-length execute of 1 to 3 states. Short instructions and untaken conditional jumps terminate early, and the block counts retired instructions.

## Interface
- No parameters.
- Iclk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  when high, the sequencer fetches; when low, it parks in IDLE at the next instruction boundary.
- ir  in  8  instruction register contents; valid from T3 onward.
- flags  in  4  {C, A, E, Z} from the FLAGS register.
- seq1..seq6  out  1 each  one-hot T-state lines; all low in IDLE.
- cpt4, cpt5, cpt6, LD4, LD5, ST4, ST5, DATA4, DATA5, DATA6, JMPR4, JMP4, JMP5, JCON4, JCON5, JCON6, CLR4, DISP4  out  1 each  phase strobes.
- last  out  1  high during the final T-state of the current instruction.
- halted  out  1  high in IDLE.
- icount  out  16  count of retired instructions.

## Operation
- States are IDLE and T1..T6, one-hot encoded. seqN = (state == TN).
- Decode uses ir[7:4]. Mnemonic, strobes and final state for each class:
  - ir[7]=1 ALU: cpt4, cpt5, cpt6; ends at T6.
  - 0000 LD: LD4, LD5; ends at T5.
  - 0001 ST: ST4, ST5; ends at T5.
  - 0010 DATA: DATA4, DATA5, DATA6; ends at T6.
  - 0011 JMPR: JMPR4; ends at T4.
  - 0100 JMP: JMP4, JMP5; ends at T5.
  - 0101 JCON: JCON4, JCON5, and JCON6 only if taken. Taken = |(ir[3:0] & flags). Ends at T6 if taken, at T5 if not.
  - 0110 CLR: CLR4; ends at T4.
  - 0111 DISP: DISP4; ends at T4.
- A strobe XN is asserted exactly when seqN=1 and the opcode selects it. Strobes are combinational from state, ir and flags, and carry no extra register delay.
- State transitions:
  - IDLE→T1 if run=1; otherwise stay in IDLE.
  - T1→T2→T3→T4 unconditionally.
  - In T4..T6: if last=0, advance to the next T-state.
  - If last=1, go to T1 when run=1, or to IDLE when run=0.
- last is computed per the decode table above. For JCON in T5, last = !taken.
- icount increments by 1 on every edge where last=1. It wraps 0xFFFF→0x0000.
- run is sampled only in IDLE and when last=1. Deasserting run mid-instruction never truncates that instruction.
- ir values outside the table do not exist: the 8 low opcodes plus ir[7]=1 cover the full space.

## Timing
- Reset (async assert) values:
  - state=IDLE.
  - All seq and strobe outputs = 0, last=0.
  - halted=1, icount=0.
- Reset deassertion is synchronised by the integrator. The first rising edge with run=1 enters T1.
- Assertion of rst_n=0 mid-instruction forces IDLE immediately, with no partial retirement. icount clears.
- Latency:
  - run=1 in IDLE → seq1 high after 1 edge.
  - Instruction lengths are 4 (JMPR, CLR, DISP), 5 (LD, ST, JMP, untaken JCON) or 6 (ALU, DATA, taken JCON) cycles.
  - Back-to-back instructions have no gap: T(last)→T1.
- flags must be stable through T5 and T6 of a JCON; no flags write occurs in JCON.
- The ir write happens at the T2 edge, so decode outputs are defined only in T4..T6. seq1..seq3 never coincide with a strobe.
- halted = (state == IDLE), registered-state derived.

## Test plan
- Reset, then hold run=0 for 5 cycles → halted=1, all seq=0, icount=0. Raise run → next edge seq1=1, halted=0.
- Execute in sequence: ir=0x00 (LD) then ir=0x80 (ALU), run=1 → seq1..seq5 with LD4 at T4 and LD5 at T5. This is followed immediately by seq1..seq6 with cpt4/5/6 at T4/5/6, and icount=2.
- JCON ir=0x51 with flags=0001 → JCON4, JCON5, JCON6 asserted, 6 cycles. Repeat with flags=1110 → JCON6 never asserted, last=1 in T5, next edge returns to T1.
- Execute ir=0x30 (JMPR) with run dropped during T2 → JMPR4 asserted at T4, last=1 in T4. The next state is IDLE, halted=1, icount=1.
- Assert rst_n=0 asynchronously during T5 of a DATA instruction (ir=0x20) → all outputs clear without waiting for an Iclk edge, and state=IDLE.
- Preload by running 65535 CLR instructions (ir=0x60), then 1 more → icount wraps to 0x0000.
